// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: shared FSM states, default geometry and parity helper for the memory bank
package mem_bank_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ADDR_W      = 15;
  localparam int DEF_DEPTH       = 32768;
  localparam int DEF_ROM_WORDS   = 16384;
  localparam int DEF_WAIT_STATES = 2;
  // Even parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/mem_bank_array.sv
// mem_bank_array: single-port synchronous word storage with registered, enabled read
// Ports: clk, rst_n (async active-low, clears only the read register);
//   wr_en/rd_en strobes, addr word address, wdata write word, rdata read register (holds between reads).
module mem_bank_array
  import mem_bank_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[addr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
endmodule

// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl: clocked request/ack memory bank with ROM region, wait states and error signalling
// Ports: clk, rst_n (async active-low); req/we/addr/wdata access request, sampled only in IDLE;
//   rom_lock write-protects [0, ROM_WORDS-1], sampled at acceptance;
//   busy (acceptance+1 .. ack), ack (one-cycle completion), err (with ack on reject),
//   rdata (read data, held until the next successful read).
// Build option MEM_BANK_PARITY_EN: stores an even-parity bit per word, flags mismatches on read
//   via err, and adds the inj_par_err input that inverts the stored parity of a write.
module mem_bank_ctrl
  import mem_bank_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ROM_WORDS   = DEF_ROM_WORDS,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rom_lock,
`ifdef MEM_BANK_PARITY_EN
  input  logic              inj_par_err,
`endif
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);
`ifdef MEM_BANK_PARITY_EN
  localparam int W = DATA_W + 1;
`else
  localparam int W = DATA_W;
`endif
  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              go, rej, we_q, rej_q, par_bad;
  logic [ADDR_W-1:0] addr_q;
  logic [W-1:0]      w_word, word_q, rd_word;
  // Compared at 64 bits so DEPTH == 2**ADDR_W and ROM_WORDS >= DEPTH need no special cases.
  assign rej = (64'(addr) >= 64'(DEPTH)) || (we && rom_lock && 64'(addr) < 64'(ROM_WORDS));
`ifdef MEM_BANK_PARITY_EN
  assign w_word  = {even_par(64'(wdata)) ^ inj_par_err, wdata};
  assign par_bad = rd_word[DATA_W] != even_par(64'(rd_word[DATA_W-1:0]));
`else
  assign w_word  = wdata;
  assign par_bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      rej_q  <= 1'b0;
      addr_q <= '0;
      word_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req) begin
        we_q   <= we;
        rej_q  <= rej;
        addr_q <= addr;
        word_q <= w_word;
      end
    end
  // The array access happens on the WAIT->DONE edge so data and ack appear together in DONE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    go      = 1'b0;
    case (state)
      IDLE: begin
        state_n = req ? WAIT : IDLE;
        cnt_n   = req ? 4'(WAIT_STATES) : cnt;
      end
      WAIT: begin
        go      = cnt == 4'd0;
        state_n = go ? DONE : WAIT;
        cnt_n   = go ? cnt : cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  mem_bank_array #(.W(W), .DEPTH(DEPTH), .AW(ADDR_W)) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .wr_en(go && we_q && !rej_q),
    .rd_en(go && !we_q && !rej_q),
    .addr (addr_q),
    .wdata(word_q),
    .rdata(rd_word)
  );
  assign busy  = state != IDLE;
  assign ack   = state == DONE;
  assign err   = ack && (rej_q || (!we_q && par_bad));
  assign rdata = rd_word[DATA_W-1:0];
endmodule
